// File: rtl/msg_validator.sv
// msg_validator: scans MSG_LEN bytes of the decrypted-message RAM and accepts a key only if every byte is 'a'..'z' or space.
// Optional build macro MSG_VALIDATOR_EARLY_EXIT_EN stops the scan at the first invalid byte.
`timescale 1ns/1ps
module msg_validator #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_sig,
   input  logic [7:0]        ram_out,
   output logic [ADDR_W-1:0] address,
   output logic              finished,
   output logic              key_valid,
   output logic [ADDR_W-1:0] fail_index,
   output logic [ADDR_W:0]   bad_count
);

   typedef enum logic [2:0] {IDLE, ADDR, WAIT, CHECK, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] address_n;
   logic [ADDR_W-1:0] fail_index_n;
   logic [ADDR_W:0]   bad_count_n;
   logic              finished_n;
   logic              key_valid_n;
   logic              byte_ok;

   assign byte_ok = ((ram_out >= 8'h61) && (ram_out <= 8'h7A)) || (ram_out == 8'h20);

   // State and result registers; reset wins even in the middle of a scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         address    <= '0;
         finished   <= 1'b0;
         key_valid  <= 1'b0;
         fail_index <= '0;
         bad_count  <= '0;
      end else begin
         state      <= state_n;
         address    <= address_n;
         finished   <= finished_n;
         key_valid  <= key_valid_n;
         fail_index <= fail_index_n;
         bad_count  <= bad_count_n;
      end
   end

   // ADDR and WAIT cover the RAM's registered address plus its read path, so CHECK sees the byte for the current address.
   always_comb begin
      state_n      = state;
      address_n    = address;
      finished_n   = finished;
      key_valid_n  = key_valid;
      fail_index_n = fail_index;
      bad_count_n  = bad_count;

      case (state)
         IDLE, DONE: begin
            if (start_sig) begin
               state_n      = ADDR;
               address_n    = '0;
               finished_n   = 1'b0;
               key_valid_n  = 1'b0;
               fail_index_n = '0;
               bad_count_n  = '0;
            end
         end

         ADDR: state_n = WAIT;

         WAIT: state_n = CHECK;

         CHECK: begin
            if (!byte_ok) begin
               bad_count_n = bad_count + 1'b1;
               if (bad_count == '0) begin
                  fail_index_n = address;
               end
            end

`ifdef MSG_VALIDATOR_EARLY_EXIT_EN
            if (!byte_ok) begin
               state_n     = DONE;
               finished_n  = 1'b1;
               key_valid_n = 1'b0;
            end else if (address == LAST_ADDR) begin
               state_n     = DONE;
               finished_n  = 1'b1;
               key_valid_n = (bad_count == '0);
            end else begin
               address_n = address + 1'b1;
               state_n   = ADDR;
            end
`else
            if (address == LAST_ADDR) begin
               state_n     = DONE;
               finished_n  = 1'b1;
               key_valid_n = byte_ok && (bad_count == '0);
            end else begin
               address_n = address + 1'b1;
               state_n   = ADDR;
            end
`endif
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_msg_validator.sv
// Testbench for msg_validator: table vectors, multi-cycle corner sequences and random images against a reference model.
// Expectations follow MSG_VALIDATOR_EARLY_EXIT_EN when it is defined.
`timescale 1ns/1ps
module tb_msg_validator;

   localparam int MSG_LEN = 32;
   localparam int ADDR_W  = 5;
   localparam int NO_IDX  = 63;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_sig;
   logic [7:0]        ram_out;
   logic [ADDR_W-1:0] address;
   logic              finished;
   logic              key_valid;
   logic [ADDR_W-1:0] fail_index;
   logic [ADDR_W:0]   bad_count;

   logic              start1;
   logic [7:0]        ram_out1;
   logic [0:0]        address1;
   logic              finished1;
   logic              key_valid1;
   logic [0:0]        fail_index1;
   logic [1:0]        bad_count1;

   logic [7:0]        mem [MSG_LEN];
   logic [ADDR_W-1:0] ram_addr_q;

   int checks = 0;
   int failures = 0;
   int kv_violations = 0;

   typedef struct packed {
      logic [7:0]      fill;
      logic [3:0][5:0] idx;
      logic [3:0][7:0] val;
      logic            kv;
      logic [4:0]      fi;
      logic [5:0]      bc;
      logic [6:0]      cyc;
      logic [4:0]      addr;
   } vec_t;

   vec_t vecs [5];

   msg_validator #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start_sig(start_sig), .ram_out(ram_out),
      .address(address), .finished(finished), .key_valid(key_valid),
      .fail_index(fail_index), .bad_count(bad_count)
   );

   msg_validator #(.MSG_LEN(1), .ADDR_W(1)) dut1 (
      .clk(clk), .reset(reset), .start_sig(start1), .ram_out(ram_out1),
      .address(address1), .finished(finished1), .key_valid(key_valid1),
      .fail_index(fail_index1), .bad_count(bad_count1)
   );

   always #5 clk = ~clk;

   // Message RAM: registered address, combinational read data.
   always @(posedge clk) ram_addr_q <= address;
   assign ram_out = mem[ram_addr_q];

   always @(negedge clk) begin
      if (!reset && ((key_valid && !finished) || (key_valid1 && !finished1))) kv_violations++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Pulses start and counts edges after the start edge until finished rises.
   task automatic applyStimulus(input bit extra_starts, output int n);
      @(negedge clk) start_sig = 1'b1;
      @(negedge clk) start_sig = 1'b0;
      n = 0;
      checkOutput("finished_cleared_by_start", finished, 0);
      while (n < 400) begin
         @(negedge clk);
         n++;
         start_sig = 1'b0;
         if (finished) break;
         if (extra_starts && (n == 10 || n == 50 || n == 95)) start_sig = 1'b1;
      end
   endtask

   task automatic modelScan(output logic kv, output int fi, output int bc, output int cyc, output int last);
      int first = -1;
      int total = 0;
      for (int i = 0; i < MSG_LEN; i++) begin
         if (!(mem[i] inside {[8'h61:8'h7A], 8'h20})) begin
            total++;
            if (first < 0) first = i;
         end
      end
`ifdef MSG_VALIDATOR_EARLY_EXIT_EN
      if (first >= 0) begin
         kv = 1'b0; fi = first; bc = 1; cyc = 3 * first + 3; last = first;
      end else begin
         kv = 1'b1; fi = 0; bc = 0; cyc = 3 * MSG_LEN; last = MSG_LEN - 1;
      end
`else
      kv = (total == 0); fi = (first < 0) ? 0 : first; bc = total;
      cyc = 3 * MSG_LEN; last = MSG_LEN - 1;
`endif
   endtask

   task automatic runModelCheck(input string tag, input bit extra_starts);
      logic kv;
      int fi, bc, cyc, last, n;
      modelScan(kv, fi, bc, cyc, last);
      applyStimulus(extra_starts, n);
      checkOutput({tag, "_cycles"}, n, cyc);
      checkOutput({tag, "_key_valid"}, key_valid, kv);
      checkOutput({tag, "_fail_index"}, fail_index, fi);
      checkOutput({tag, "_bad_count"}, bad_count, bc);
      checkOutput({tag, "_address"}, address, last);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_address"}, address, 0);
      checkOutput({tag, "_finished"}, finished, 0);
      checkOutput({tag, "_key_valid"}, key_valid, 0);
      checkOutput({tag, "_fail_index"}, fail_index, 0);
      checkOutput({tag, "_bad_count"}, bad_count, 0);
   endtask

   task automatic runSingle(input logic [7:0] b, input logic kv, input int bc);
      int n = 0;
      ram_out1 = b;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      while (!finished1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("len1_cycles", n, 3);
      checkOutput("len1_key_valid", key_valid1, kv);
      checkOutput("len1_fail_index", fail_index1, 0);
      checkOutput("len1_bad_count", bad_count1, bc);
   endtask

   function automatic logic [7:0] randByte(input bit allow_bad);
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 15);
      if (!allow_bad || r < 11) begin
         b = ($urandom_range(0, 4) == 0) ? 8'h20 : 8'(97 + $urandom_range(0, 25));
      end else begin
         case (r)
            11:      b = 8'h60;
            12:      b = 8'h7B;
            13:      b = 8'h1F;
            14:      b = 8'h21;
            default: b = 8'($urandom_range(128, 255));
         endcase
      end
      return b;
   endfunction

   initial begin
      int n;
      vecs[0] = '{fill:8'h61, idx:{6'd63, 6'd63, 6'd63, 6'd63}, val:{8'h0, 8'h0, 8'h0, 8'h0},
                  kv:1'b1, fi:5'd0, bc:6'd0, cyc:7'd96, addr:5'd31};
      vecs[3] = '{fill:8'h20, idx:{6'd63, 6'd63, 6'd63, 6'd31}, val:{8'h0, 8'h0, 8'h0, 8'h7B},
                  kv:1'b0, fi:5'd31, bc:6'd1, cyc:7'd96, addr:5'd31};
      vecs[4] = '{fill:8'h61, idx:{6'd63, 6'd63, 6'd11, 6'd10}, val:{8'h0, 8'h0, 8'h20, 8'h7A},
                  kv:1'b1, fi:5'd0, bc:6'd0, cyc:7'd96, addr:5'd31};
`ifdef MSG_VALIDATOR_EARLY_EXIT_EN
      vecs[1] = '{fill:8'h20, idx:{6'd63, 6'd63, 6'd20, 6'd5}, val:{8'h0, 8'h0, 8'h7B, 8'h41},
                  kv:1'b0, fi:5'd5, bc:6'd1, cyc:7'd18, addr:5'd5};
      vecs[2] = '{fill:8'h7A, idx:{6'd31, 6'd30, 6'd1, 6'd0}, val:{8'h21, 8'h1F, 8'h7B, 8'h60},
                  kv:1'b0, fi:5'd0, bc:6'd1, cyc:7'd3, addr:5'd0};
`else
      vecs[1] = '{fill:8'h20, idx:{6'd63, 6'd63, 6'd20, 6'd5}, val:{8'h0, 8'h0, 8'h7B, 8'h41},
                  kv:1'b0, fi:5'd5, bc:6'd2, cyc:7'd96, addr:5'd31};
      vecs[2] = '{fill:8'h7A, idx:{6'd31, 6'd30, 6'd1, 6'd0}, val:{8'h21, 8'h1F, 8'h7B, 8'h60},
                  kv:1'b0, fi:5'd0, bc:6'd4, cyc:7'd96, addr:5'd31};
`endif

      reset = 1'b1; start_sig = 1'b0; start1 = 1'b0; ram_out1 = 8'h20;
      for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h61;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      checkOutput("reset_len1_finished", finished1, 0);
      reset = 1'b0;

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < MSG_LEN; i++) mem[i] = vecs[v].fill;
         for (int j = 0; j < 4; j++) begin
            if (vecs[v].idx[j] != NO_IDX) mem[vecs[v].idx[j]] = vecs[v].val[j];
         end
         applyStimulus(1'b0, n);
         checkOutput($sformatf("vec%0d_cycles", v), n, vecs[v].cyc);
         checkOutput($sformatf("vec%0d_key_valid", v), key_valid, vecs[v].kv);
         checkOutput($sformatf("vec%0d_fail_index", v), fail_index, vecs[v].fi);
         checkOutput($sformatf("vec%0d_bad_count", v), bad_count, vecs[v].bc);
         checkOutput($sformatf("vec%0d_address", v), address, vecs[v].addr);
         repeat (3) @(negedge clk);
         checkOutput($sformatf("vec%0d_hold_finished", v), finished, 1);
         checkOutput($sformatf("vec%0d_hold_bad_count", v), bad_count, vecs[v].bc);
      end

      // Reset 40 cycles into a scan, then confirm the block sits idle.
      for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h20;
      mem[5] = 8'h41; mem[20] = 8'h7B;
      @(negedge clk) start_sig = 1'b1;
      @(negedge clk) start_sig = 1'b0;
      repeat (39) @(negedge clk);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      checkResetValues("midscan_reset");
      repeat (10) @(negedge clk);
      checkOutput("idle_after_reset_address", address, 0);
      checkOutput("idle_after_reset_finished", finished, 0);
      runModelCheck("after_reset", 1'b0);

      runModelCheck("extra_starts", 1'b1);

      for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h61;
      runModelCheck("restart_from_done", 1'b0);
      checkOutput("restart_key_valid", key_valid, 1);

      runSingle(8'h20, 1'b1, 0);
      runSingle(8'h21, 1'b0, 1);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < MSG_LEN; i++) mem[i] = randByte(r != 0);
         runModelCheck($sformatf("rand%0d", r), r[0]);
      end

      checkOutput("key_valid_without_finished", kv_violations, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
